// File: rtl/lsu.sv
// Load/store unit: one outstanding doubleword-bus access with lane steering,
// load extension, misalignment detection and a memory-timeout abort.
package lsu_pkg;
  typedef enum logic [3:0] {
    LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU,
    LSU_SB, LSU_SH, LSU_SW, LSU_SD
  } lsu_op_t;
endpackage

module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  lsu_op_t        lsu_op_i,
  input  logic [63:0]    addr_i,
  input  logic [63:0]    wdata_i,
  input  logic [4:0]     rd_addr_i,
  output logic           resp_valid_o,
  output logic [63:0]    rdata_o,
  output logic [4:0]     rd_addr_o,
  output logic           misaligned_o,
  output logic           err_o,
  output logic           mem_req_o,
  output logic           mem_we_o,
  output logic [63:0]    mem_addr_o,
  output logic [7:0]     mem_be_o,
  output logic [63:0]    mem_wdata_o,
  input  logic           mem_gnt_i,
  input  logic           mem_rvalid_i,
  input  logic [63:0]    mem_rdata_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

  function automatic logic [1:0] op_size(input lsu_op_t op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: op_size = 2'd0;
      LSU_LH, LSU_LHU, LSU_SH: op_size = 2'd1;
      LSU_LW, LSU_LWU, LSU_SW: op_size = 2'd2;
      default:                 op_size = 2'd3;
    endcase
  endfunction

  function automatic logic is_store(input lsu_op_t op);
    is_store = (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW) || (op == LSU_SD);
  endfunction

  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  lsu_op_t       op_reg;
  logic [63:0]   addr_reg;
  logic [63:0]   wdata_reg;
  logic [4:0]    rd_reg;
  logic [63:0]   rdata_reg;
  logic          mis_reg;
  logic          err_reg;

  logic          in_req;
  logic          in_done;
  logic          mis_in;
  logic [7:0]    be_base;
  logic [7:0]    be_shift;
  logic [63:0]   wdata_shift;
  logic [63:0]   rd_shift;
  logic [63:0]   load_data;
  logic          timed_out;

  always_comb begin
    mis_in = 1'b0;
    case (op_size(lsu_op_i))
      2'd1:    mis_in = addr_i[0];
      2'd2:    mis_in = |addr_i[1:0];
      2'd3:    mis_in = |addr_i[2:0];
      default: mis_in = 1'b0;
    endcase
  end

  always_comb begin
    case (op_size(op_reg))
      2'd0:    be_base = 8'h01;
      2'd1:    be_base = 8'h03;
      2'd2:    be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
  end

  assign be_shift    = be_base << addr_reg[2:0];
  assign wdata_shift = wdata_reg << {addr_reg[2:0], 3'b000};
  assign rd_shift    = mem_rdata_i >> {addr_reg[2:0], 3'b000};

  // Stores return zero so a stale bus value never reaches the register file.
  always_comb begin
    case (op_reg)
      LSU_LB:  load_data = {{56{rd_shift[7]}}, rd_shift[7:0]};
      LSU_LH:  load_data = {{48{rd_shift[15]}}, rd_shift[15:0]};
      LSU_LW:  load_data = {{32{rd_shift[31]}}, rd_shift[31:0]};
      LSU_LBU: load_data = {56'd0, rd_shift[7:0]};
      LSU_LHU: load_data = {48'd0, rd_shift[15:0]};
      LSU_LWU: load_data = {32'd0, rd_shift[31:0]};
      LSU_LD:  load_data = rd_shift;
      default: load_data = 64'd0;
    endcase
  end

  assign timed_out = (cnt_reg == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= LSU_NONE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_reg    <= '0;
      rdata_reg <= '0;
      mis_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid_i && lsu_op_i != LSU_NONE) begin
            op_reg    <= lsu_op_i;
            addr_reg  <= addr_i;
            wdata_reg <= wdata_i;
            rd_reg    <= rd_addr_i;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            mis_reg   <= mis_in;
            cnt_reg   <= '0;
            state_reg <= mis_in ? DONE : REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            if (mem_rvalid_i) begin
              rdata_reg <= load_data;
              state_reg <= DONE;
            end else begin
              state_reg <= WAIT;
            end
            cnt_reg <= cnt_reg + 1'b1;
          end else if (timed_out) begin
            err_reg   <= 1'b1;
            rdata_reg <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            rdata_reg <= load_data;
            state_reg <= DONE;
          end else if (timed_out) begin
            err_reg   <= 1'b1;
            rdata_reg <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_req  = (state_reg == REQ);
  assign in_done = (state_reg == DONE);

  assign req_ready_o  = (state_reg == IDLE);
  assign resp_valid_o = in_done;
  assign rdata_o      = in_done ? rdata_reg : 64'd0;
  assign rd_addr_o    = in_done ? rd_reg : 5'd0;
  assign misaligned_o = in_done & mis_reg;
  assign err_o        = in_done & err_reg;

  // Bus-side outputs are zero outside REQ so nothing leaks while idle.
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req & is_store(op_reg);
  assign mem_addr_o  = in_req ? {addr_reg[63:3], 3'b000} : 64'd0;
  assign mem_be_o    = in_req ? be_shift : 8'd0;
  assign mem_wdata_o = in_req ? wdata_shift : 64'd0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table of single ops plus hand sequences
// for timeout, ignored rvalid, LSU_NONE and reset-abandon cases.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  lsu_op_t     lsu_op_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [4:0]  rd_addr_i;
  logic        resp_valid_o;
  logic [63:0] rdata_o;
  logic [4:0]  rd_addr_o;
  logic        misaligned_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [7:0]  mem_be_o;
  logic [63:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .lsu_op_i(lsu_op_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
    .resp_valid_o(resp_valid_o), .rdata_o(rdata_o), .rd_addr_o(rd_addr_o),
    .misaligned_o(misaligned_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    lsu_op_t     op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mrd;
    logic        same;
    logic        mis;
    logic        we;
    logic [7:0]  be;
    logic [63:0] mwd;
    logic [63:0] rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [4:0] rd;
    rd = 5'(i + 1);
    @(negedge clk);
    chk("ready_before", req_ready_o, 1);
    req_valid_i = 1'b1; lsu_op_i = v.op; addr_i = v.addr; wdata_i = v.wdata; rd_addr_i = rd;
    @(negedge clk);
    req_valid_i = 1'b0; lsu_op_i = LSU_NONE; addr_i = '0; wdata_i = '0; rd_addr_i = '0;
    if (v.mis) begin
      chk("mis_no_req", mem_req_o, 0);
      chk("mis_resp", resp_valid_o, 1);
      chk("mis_flag", misaligned_o, 1);
      chk("mis_err", err_o, 0);
      chk("mis_rdata", rdata_o, 0);
      chk("mis_rd", rd_addr_o, rd);
    end else begin
      chk("req", mem_req_o, 1);
      chk("ready_busy", req_ready_o, 0);
      chk("maddr", mem_addr_o, {v.addr[63:3], 3'b000});
      chk("be", mem_be_o, v.be);
      chk("we", mem_we_o, v.we);
      chk("mwdata", mem_wdata_o, v.mwd);
      mem_gnt_i = 1'b1;
      if (v.same) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = v.mrd;
      end
      @(negedge clk);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      if (!v.same) begin
        chk("wait_no_resp", resp_valid_o, 0);
        chk("wait_no_req", mem_req_o, 0);
        mem_rvalid_i = 1'b1; mem_rdata_i = v.mrd;
        @(negedge clk);
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      end
      chk("resp", resp_valid_o, 1);
      chk("rdata", rdata_o, v.rdata);
      chk("misal", misaligned_o, 0);
      chk("err", err_o, 0);
      chk("rd", rd_addr_o, rd);
      chk("ready_done", req_ready_o, 0);
    end
    $display("vec %0d op=%s addr=%h rdata=%h resp=%0b", i, v.op.name(), v.addr, rdata_o, resp_valid_o);
  endtask

  initial begin
    vecs[0]  = '{LSU_LW,  64'h1004, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0000};
    vecs[1]  = '{LSU_SB,  64'h2003, 64'hAB, 64'h0, 1'b0, 1'b0, 1'b1, 8'h08, 64'hAB00_0000, 64'h0};
    vecs[2]  = '{LSU_LH,  64'h3001, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 64'h0};
    vecs[3]  = '{LSU_LBU, 64'h7, 64'h0, 64'hFF00_0000_0000_0000, 1'b1, 1'b0, 1'b0, 8'h80, 64'h0, 64'hFF};
    vecs[4]  = '{LSU_LD,  64'h10, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0, 8'hFF, 64'h0, 64'h1234_5678_9ABC_DEF0};
    vecs[5]  = '{LSU_SD,  64'h18, 64'h0123_4567_89AB_CDEF, 64'h5555, 1'b0, 1'b0, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[6]  = '{LSU_LB,  64'h22, 64'h0, 64'h0000_0000_0080_0000, 1'b0, 1'b0, 1'b0, 8'h04, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[7]  = '{LSU_LHU, 64'h46, 64'h0, 64'hBEEF_0000_0000_0000, 1'b0, 1'b0, 1'b0, 8'hC0, 64'h0, 64'hBEEF};
    vecs[8]  = '{LSU_LWU, 64'h4, 64'h0, 64'h8765_4321_0000_0000, 1'b0, 1'b0, 1'b0, 8'hF0, 64'h0, 64'h8765_4321};
    vecs[9]  = '{LSU_SH,  64'h52, 64'hFFFF_FFFF_FFFF_1234, 64'h0, 1'b0, 1'b0, 1'b1, 8'h0C, 64'hFFFF_FFFF_1234_0000, 64'h0};
    vecs[10] = '{LSU_SW,  64'h5, 64'h1, 64'h0, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 64'h0};
    vecs[11] = '{LSU_LD,  64'h9, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 64'h0};
    vecs[12] = '{LSU_SW,  64'h3C, 64'hDEAD_BEEF, 64'h0, 1'b1, 1'b0, 1'b1, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0};
    vecs[13] = '{LSU_LW,  64'h8, 64'h0, 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0, 1'b0, 8'h0F, 64'h0, 64'h7FFF_FFFF};
    vecs[14] = '{LSU_LB,  64'h3, 64'h0, 64'h0000_0000_7F00_0000, 1'b0, 1'b0, 1'b0, 8'h08, 64'h0, 64'h7F};

    rst_i = 1'b1; req_valid_i = 1'b0; lsu_op_i = LSU_NONE; addr_i = '0; wdata_i = '0;
    rd_addr_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    chk("rst_ready", req_ready_o, 1);
    chk("rst_resp", resp_valid_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_be", mem_be_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_flags", {misaligned_o, err_o, mem_we_o}, 0);
    $display("reset ready=%0b req=%0b", req_ready_o, mem_req_o);

    // LSU_NONE with valid must not start anything.
    req_valid_i = 1'b1; lsu_op_i = LSU_NONE; addr_i = 64'h100;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("none_ready", req_ready_o, 1);
    chk("none_req", mem_req_o, 0);
    chk("none_resp", resp_valid_o, 0);
    $display("none ready=%0b req=%0b", req_ready_o, mem_req_o);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Timeout: grant withheld; rvalid without grant must be ignored.
    @(negedge clk);
    req_valid_i = 1'b1; lsu_op_i = LSU_LD; addr_i = 64'h40; rd_addr_i = 5'd9;
    @(negedge clk);
    req_valid_i = 1'b0; lsu_op_i = LSU_NONE;
    for (int k = 0; k < 4; k++) begin
      chk("tmo_req", mem_req_o, 1);
      chk("tmo_addr", mem_addr_o, 64'h40);
      chk("tmo_be", mem_be_o, 8'hFF);
      chk("tmo_noresp", resp_valid_o, 0);
      mem_rvalid_i = (k == 0); mem_rdata_i = 64'hDEAD;
      @(negedge clk);
      mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    end
    chk("tmo_resp", resp_valid_o, 1);
    chk("tmo_err", err_o, 1);
    chk("tmo_mis", misaligned_o, 0);
    chk("tmo_rdata", rdata_o, 0);
    chk("tmo_req_drop", mem_req_o, 0);
    $display("timeout resp=%0b err=%0b", resp_valid_o, err_o);

    // Reset during WAIT, then a stale rvalid.
    @(negedge clk);
    req_valid_i = 1'b1; lsu_op_i = LSU_LW; addr_i = 64'h60; rd_addr_i = 5'd3;
    @(negedge clk);
    req_valid_i = 1'b0; lsu_op_i = LSU_NONE;
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("rstw_ready", req_ready_o, 1);
    chk("rstw_resp", resp_valid_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1234;
    @(negedge clk);
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    chk("rstw_stale_resp", resp_valid_o, 0);
    chk("rstw_stale_ready", req_ready_o, 1);
    chk("rstw_stale_req", mem_req_o, 0);
    $display("reset_in_wait resp=%0b ready=%0b", resp_valid_o, req_ready_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
